// File: rtl/bp_l15_store_buffer.sv
// Posted-store buffer in front of the BlackParrot-to-L1.5 transducer.
// Stores are acked on enqueue and drained in order; loads wait until every
// older store has drained, and fence_i blocks new requests until empty.
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   req_*                        dcache request (valid/ready handshake)
//   fence_i                      block new requests until the buffer is empty
//   empty_o, count_o             buffer status
//   miss_*_o / miss_yumi_i       request to the transducer and its consume strobe
module bp_l15_store_buffer #(
  parameter int unsigned els_p         = 4,
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned way_width_p   = 3,
  parameter int unsigned dword_width_p = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_v_i,
  output logic                         req_ready_o,
  input  logic                         req_store_i,
  input  logic                         req_uncached_i,
  input  logic [paddr_width_p-1:0]     req_addr_i,
  input  logic [way_width_p-1:0]       req_way_i,
  input  logic [dword_width_p-1:0]     req_data_i,
  input  logic [1:0]                   req_size_i,
  input  logic                         fence_i,
  output logic                         empty_o,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         miss_v_o,
  output logic                         miss_uncached_o,
  output logic [paddr_width_p-1:0]     miss_addr_o,
  output logic [way_width_p-1:0]       miss_lru_way_o,
  output logic                         miss_store_o,
  output logic [dword_width_p-1:0]     miss_store_data_o,
  output logic [1:0]                   miss_size_op_o,
  input  logic                         miss_yumi_i
);

  localparam int unsigned cnt_w = $clog2(els_p + 1);
  localparam int unsigned ptr_w = $clog2(els_p);

  typedef enum logic [1:0] {e_idle, e_load_wait, e_load_issue} state_e;

  state_e                   state_q, state_d;
  logic [cnt_w-1:0]         count_q, count_d;
  logic [ptr_w-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     fence_blk_q, fence_blk_d;
  logic                     ld_uncached_q, ld_uncached_d;
  logic [paddr_width_p-1:0] ld_addr_q, ld_addr_d;
  logic [way_width_p-1:0]   ld_way_q, ld_way_d;
  logic [1:0]               ld_size_q, ld_size_d;

  // FIFO storage; contents are only observed while count_q covers the entry
  logic                     uncached_mem [els_p];
  logic [paddr_width_p-1:0] addr_mem     [els_p];
  logic [way_width_p-1:0]   way_mem      [els_p];
  logic [dword_width_p-1:0] data_mem     [els_p];
  logic [1:0]               size_mem     [els_p];

  logic full, fence_blk, push, ld_acc, pop, ld_done;

  // Handshakes, output mux and next-state logic
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    ld_uncached_d   = ld_uncached_q;
    ld_addr_d       = ld_addr_q;
    ld_way_d        = ld_way_q;
    ld_size_d       = ld_size_q;
    miss_uncached_o   = 1'b0;
    miss_addr_o       = '0;
    miss_lru_way_o    = '0;
    miss_store_o      = 1'b0;
    miss_store_data_o = '0;
    miss_size_op_o    = 2'b00;

    full      = (count_q == cnt_w'(els_p));
    empty_o   = (count_q == '0) && (state_q == e_idle);
    count_o   = count_q;
    // A fence on a non-empty buffer blocks in its own cycle, then via the flop
    fence_blk   = fence_blk_q | (fence_i & ~empty_o);
    fence_blk_d = fence_blk & ~empty_o;

    req_ready_o = ~reset_i && (state_q == e_idle) && ~fence_blk &&
                  (req_store_i ? ~full : 1'b1);
    push   = req_v_i & req_ready_o & req_store_i;
    ld_acc = req_v_i & req_ready_o & ~req_store_i;

    // Stores always go ahead of a held load
    miss_v_o = (count_q != '0) || (state_q == e_load_issue);
    if (count_q != '0) begin
      miss_uncached_o   = uncached_mem[rd_ptr_q];
      miss_addr_o       = addr_mem[rd_ptr_q];
      miss_lru_way_o    = way_mem[rd_ptr_q];
      miss_store_o      = 1'b1;
      miss_store_data_o = data_mem[rd_ptr_q];
      miss_size_op_o    = size_mem[rd_ptr_q];
    end else if (state_q == e_load_issue) begin
      miss_uncached_o = ld_uncached_q;
      miss_addr_o     = ld_addr_q;
      miss_lru_way_o  = ld_way_q;
      miss_size_op_o  = ld_size_q;
    end

    pop     = miss_yumi_i && (count_q != '0);
    ld_done = miss_yumi_i && (count_q == '0) && (state_q == e_load_issue);

    if (push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
    count_d = count_q + cnt_w'(push) - cnt_w'(pop);

    if (ld_acc) begin
      ld_uncached_d = req_uncached_i;
      ld_addr_d     = req_addr_i;
      ld_way_d      = req_way_i;
      ld_size_d     = req_size_i;
    end

    case (state_q)
      e_idle:       if (ld_acc) state_d = (count_q != '0) ? e_load_wait : e_load_issue;
      // Also covers a load accepted in the cycle the last store popped
      e_load_wait:  if (count_d == '0) state_d = e_load_issue;
      e_load_issue: if (ld_done) state_d = e_idle;
      default:      state_d = e_idle;
    endcase
  end

  // Control and load-register flops
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_idle;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fence_blk_q   <= 1'b0;
      ld_uncached_q <= 1'b0;
      ld_addr_q     <= '0;
      ld_way_q      <= '0;
      ld_size_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fence_blk_q   <= fence_blk_d;
      ld_uncached_q <= ld_uncached_d;
      ld_addr_q     <= ld_addr_d;
      ld_way_q      <= ld_way_d;
      ld_size_q     <= ld_size_d;
    end
  end

  // FIFO write port
  always_ff @(posedge clk_i) begin
    if (push) begin
      uncached_mem[wr_ptr_q] <= req_uncached_i;
      addr_mem[wr_ptr_q]     <= req_addr_i;
      way_mem[wr_ptr_q]      <= req_way_i;
      data_mem[wr_ptr_q]     <= req_data_i;
      size_mem[wr_ptr_q]     <= req_size_i;
    end
  end

  // A consume strobe with nothing presented is a transducer protocol error
  always @(posedge clk_i) begin
    if (!reset_i && miss_yumi_i)
      assert (miss_v_o) else $error("miss_yumi_i asserted while miss_v_o=0");
  end

endmodule

// File: tb/tb_bp_l15_store_buffer.sv
// Directed bench for bp_l15_store_buffer: ordering, full, load hold, fence, reset.
module tb_bp_l15_store_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_v_i, req_ready_o, req_store_i, req_uncached_i;
  logic [39:0] req_addr_i;
  logic [2:0]  req_way_i;
  logic [63:0] req_data_i;
  logic [1:0]  req_size_i;
  logic        fence_i, empty_o;
  logic [2:0]  count_o;
  logic        miss_v_o, miss_uncached_o, miss_store_o, miss_yumi_i;
  logic [39:0] miss_addr_o;
  logic [2:0]  miss_lru_way_o;
  logic [63:0] miss_store_data_o;
  logic [1:0]  miss_size_op_o;

  int errors = 0;
  int checks = 0;

  bp_l15_store_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_uncached_i(req_uncached_i), .req_addr_i(req_addr_i), .req_way_i(req_way_i),
    .req_data_i(req_data_i), .req_size_i(req_size_i), .fence_i(fence_i),
    .empty_o(empty_o), .count_o(count_o),
    .miss_v_o(miss_v_o), .miss_uncached_o(miss_uncached_o), .miss_addr_o(miss_addr_o),
    .miss_lru_way_o(miss_lru_way_o), .miss_store_o(miss_store_o),
    .miss_store_data_o(miss_store_data_o), .miss_size_op_o(miss_size_op_o),
    .miss_yumi_i(miss_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Offer a request, expect it accepted, then drop valid after the edge
  task automatic send(input logic st, input logic unc, input logic [39:0] a,
                      input logic [2:0] w, input logic [63:0] d, input logic [1:0] sz);
    req_v_i = 1'b1; req_store_i = st; req_uncached_i = unc;
    req_addr_i = a; req_way_i = w; req_data_i = d; req_size_i = sz;
    #1;
    chk("send_ready", 64'(req_ready_o), 64'd1);
    cyc();
    req_v_i = 1'b0;
  endtask

  task automatic yumi();
    miss_yumi_i = 1'b1;
    cyc();
    miss_yumi_i = 1'b0;
  endtask

  logic [39:0] exp_addr [4];

  initial begin
    reset_i = 1'b1; req_v_i = 1'b1; req_store_i = 1'b1; req_uncached_i = 1'b0;
    req_addr_i = '0; req_way_i = '0; req_data_i = '0; req_size_i = 2'd3;
    fence_i = 1'b0; miss_yumi_i = 1'b0;
    #1;
    chk("ready_in_reset", 64'(req_ready_o), 64'd0);
    cyc(); cyc();
    req_v_i = 1'b0;
    reset_i = 1'b0;
    #1;
    chk("rst_miss_v", 64'(miss_v_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_addr", 64'(miss_addr_o), 64'd0);

    // In-order drain of three stores
    send(1'b1, 1'b0, 40'h80000000, 3'd1, 64'hA0, 2'd3);
    chk("lat_miss_v", 64'(miss_v_o), 64'd1);
    chk("lat_count", 64'(count_o), 64'd1);
    send(1'b1, 1'b0, 40'h80000008, 3'd2, 64'hA1, 2'd3);
    send(1'b1, 1'b0, 40'h80000010, 3'd3, 64'hA2, 2'd3);
    chk("t1_count", 64'(count_o), 64'd3);
    chk("t1_head_addr", 64'(miss_addr_o), 64'h80000000);
    chk("t1_head_data", 64'(miss_store_data_o), 64'hA0);
    chk("t1_head_store", 64'(miss_store_o), 64'd1);
    chk("t1_head_way", 64'(miss_lru_way_o), 64'd1);
    exp_addr[0] = 40'h80000000; exp_addr[1] = 40'h80000008;
    exp_addr[2] = 40'h80000010; exp_addr[3] = 40'h0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_order_addr", 64'(miss_addr_o), 64'(exp_addr[i]));
      chk("t1_order_v", 64'(miss_v_o), 64'd1);
      yumi();
    end
    chk("t1_drained_v", 64'(miss_v_o), 64'd0);
    chk("t1_drained_empty", 64'(empty_o), 64'd1);

    // Full: fifth store refused even with a same-cycle pop
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b0, 40'h90000000 + 40'(i * 8), 3'd0, 64'(i), 2'd2);
    chk("t2_full_count", 64'(count_o), 64'd4);
    req_v_i = 1'b1; req_store_i = 1'b1; req_addr_i = 40'h90000020; req_data_i = 64'd4;
    miss_yumi_i = 1'b1;
    #1;
    chk("t2_full_ready", 64'(req_ready_o), 64'd0);
    cyc();
    miss_yumi_i = 1'b0;
    #1;
    chk("t2_after_pop_count", 64'(count_o), 64'd3);
    chk("t2_after_pop_ready", 64'(req_ready_o), 64'd1);
    cyc();
    req_v_i = 1'b0;
    chk("t2_refill_count", 64'(count_o), 64'd4);
    chk("t2_head_addr", 64'(miss_addr_o), 64'h90000008);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wrap_addr", 64'(miss_addr_o), 64'h90000008 + 64'(i * 8));
      yumi();
    end
    chk("t2_empty", 64'(empty_o), 64'd1);

    // Load held behind two stores
    send(1'b1, 1'b0, 40'h80000100, 3'd0, 64'hB0, 2'd3);
    send(1'b1, 1'b0, 40'h80000108, 3'd0, 64'hB1, 2'd3);
    send(1'b0, 1'b0, 40'h80000040, 3'd5, 64'hDEAD, 2'd3);
    chk("t3_store_first", 64'(miss_store_o), 64'd1);
    chk("t3_store_first_addr", 64'(miss_addr_o), 64'h80000100);
    chk("t3_not_empty", 64'(empty_o), 64'd0);
    req_v_i = 1'b1; req_store_i = 1'b1; #1;
    chk("t3_refuse_wait", 64'(req_ready_o), 64'd0);
    req_v_i = 1'b0;
    yumi();
    chk("t3_second_store", 64'(miss_addr_o), 64'h80000108);
    chk("t3_second_is_store", 64'(miss_store_o), 64'd1);
    yumi();
    chk("t3_load_v", 64'(miss_v_o), 64'd1);
    chk("t3_load_store", 64'(miss_store_o), 64'd0);
    chk("t3_load_addr", 64'(miss_addr_o), 64'h80000040);
    chk("t3_load_way", 64'(miss_lru_way_o), 64'd5);
    chk("t3_load_data", 64'(miss_store_data_o), 64'd0);
    chk("t3_count0", 64'(count_o), 64'd0);
    req_v_i = 1'b1; req_store_i = 1'b0; #1;
    chk("t3_refuse_issue", 64'(req_ready_o), 64'd0);
    req_v_i = 1'b0;
    yumi();
    chk("t3_done_v", 64'(miss_v_o), 64'd0);
    chk("t3_done_empty", 64'(empty_o), 64'd1);

    // Uncached load into an empty buffer
    send(1'b0, 1'b1, 40'h00001234, 3'd2, 64'd0, 2'd1);
    chk("t4_v", 64'(miss_v_o), 64'd1);
    chk("t4_uncached", 64'(miss_uncached_o), 64'd1);
    chk("t4_addr", 64'(miss_addr_o), 64'h1234);
    chk("t4_size", 64'(miss_size_op_o), 64'd1);
    chk("t4_store", 64'(miss_store_o), 64'd0);
    req_v_i = 1'b1; req_store_i = 1'b1; #1;
    chk("t4_refuse_store", 64'(req_ready_o), 64'd0);
    cyc();
    chk("t4_stable_addr", 64'(miss_addr_o), 64'h1234);
    req_v_i = 1'b0;
    yumi();
    chk("t4_empty", 64'(empty_o), 64'd1);

    // Fence: no effect when empty, blocks until drained otherwise
    fence_i = 1'b1; req_v_i = 1'b1; req_store_i = 1'b1; #1;
    chk("t5_fence_empty_ready", 64'(req_ready_o), 64'd1);
    fence_i = 1'b0; req_v_i = 1'b0;
    cyc();
    send(1'b1, 1'b0, 40'h80000200, 3'd0, 64'hC0, 2'd3);
    send(1'b1, 1'b0, 40'h80000208, 3'd0, 64'hC1, 2'd3);
    fence_i = 1'b1; req_v_i = 1'b1; req_store_i = 1'b1; #1;
    chk("t5_fence_cycle", 64'(req_ready_o), 64'd0);
    cyc();
    fence_i = 1'b0; #1;
    chk("t5_blk_2", 64'(req_ready_o), 64'd0);
    yumi(); #1;
    chk("t5_blk_1", 64'(req_ready_o), 64'd0);
    yumi(); #1;
    chk("t5_empty_now", 64'(empty_o), 64'd1);
    chk("t5_blk_empty_cycle", 64'(req_ready_o), 64'd0);
    cyc();
    chk("t5_ready_back", 64'(req_ready_o), 64'd1);
    req_v_i = 1'b0;

    // Reset discards buffered stores and a held load
    send(1'b1, 1'b0, 40'h80000300, 3'd0, 64'hD0, 2'd3);
    send(1'b1, 1'b0, 40'h80000308, 3'd0, 64'hD1, 2'd3);
    send(1'b1, 1'b0, 40'h80000310, 3'd0, 64'hD2, 2'd3);
    send(1'b0, 1'b0, 40'h80000380, 3'd4, 64'd0, 2'd3);
    chk("t6_pre_count", 64'(count_o), 64'd3);
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    #1;
    chk("t6_miss_v", 64'(miss_v_o), 64'd0);
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_empty", 64'(empty_o), 64'd1);
    chk("t6_addr", 64'(miss_addr_o), 64'd0);
    cyc(); cyc();
    chk("t6_no_residual", 64'(miss_v_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
